oled_spi_master: RTL and testbench
==================================

// Module: oled_spi_master
// PURPOSE
//  Drives the Pmod OLED RGB pin set (sclk, cs, mosi, dc_c, res, vss_en, pmod_en).
//  Serialises command/data words over SPI mode 3 (sclk idle high, MSB first)
//  with a parametrised divider and word width.
//  Also owns the panel power sequence: VDD on, reset pulse, VCC gated, ordered power-down.
//  Sits between the display controller (valid/ready word stream) and the Pmod pins.
// PARAMETERS
//  CLK_DIV        4    clk cycles per sclk half-period (>=1)
//  DATA_W         8    bits per SPI word (>=1)
//  CS_GAP         2    clk cycles cs held high between words (>=1)
//  PWR_DELAY      1000 clk cycles from pmod_en rise to reset assert
//  RES_CYCLES     500  clk cycles res held low, and again high before ready
//  VCC_OFF_DELAY  1000 clk cycles from vss_en fall to pmod_en fall
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  pwr_on_req  in   1       level: 1 = power panel up, 0 = power down
//  vcc_req     in   1       level: request VCC (vss_en); honoured only when pwr_ready
//  pwr_ready   out  1       power sequence complete, SPI usable
//  tx_valid    in   1       word available
//  tx_ready    out  1       block accepts word this cycle
//  tx_data     in   DATA_W  word to send, MSB first
//  tx_dc       in   1       0 = command, 1 = data; copied to dc_c
//  busy        out  1       frame or cs gap in progress
//  sclk        out  1       SPI clock
//  cs          out  1       chip select, active low
//  mosi        out  1       serial data
//  dc_c        out  1       data/command select
//  res         out  1       panel reset, active low
//  vss_en      out  1       VCC enable
//  pmod_en     out  1       VDD logic enable
// BEHAVIOUR
//  Reset (async, rst_n=0): cs=1 sclk=1 mosi=0 dc_c=0 res=0 vss_en=0 pmod_en=0
//   pwr_ready=0 tx_ready=0 busy=0; both FSMs to idle/OFF; all counters cleared.
//  All outputs registered.
//  Power FSM: OFF -> VDD_ON -> RES_LO -> RES_HI -> READY -> PWR_DOWN -> OFF.
//   OFF: pmod_en=0 res=0. pwr_on_req=1 sampled -> VDD_ON next cycle.
//   VDD_ON: pmod_en=1 res=1 for PWR_DELAY cycles.
//   RES_LO: res=0 for RES_CYCLES cycles.
//   RES_HI: res=1 for RES_CYCLES cycles.
//   READY: pwr_ready=1; vss_en=vcc_req (registered, 1 cycle).
//   pwr_on_req=0 in VDD_ON/RES_LO/RES_HI -> OFF next cycle (no VCC was on).
//   pwr_on_req=0 in READY: pwr_ready=0 next cycle, no new words accepted.
//    Any frame in flight (incl. its CS_GAP) completes first.
//    Then PWR_DOWN: vss_en=0, wait VCC_OFF_DELAY, then OFF.
//   pwr_on_req=1 again during PWR_DOWN: ignored until OFF reached.
//  SPI FSM: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
//   tx_ready = (IDLE & power READY & pwr_on_req). Accept on tx_valid&tx_ready.
//   Accept cycle: latch tx_data/tx_dc.
//    Next cycle: cs=0, dc_c=tx_dc, mosi=bit DATA_W-1, tx_ready=0, busy=1.
//   SETUP: CLK_DIV cycles, sclk=1.
//   SHIFT: per bit, sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
//    mosi moves to next bit on each falling edge after the first.
//    Peripheral samples on rising edges.
//   cs low for exactly CLK_DIV*(1+2*DATA_W) cycles; sclk=1 when cs rises.
//   GAP: cs=1, busy=1 for CS_GAP cycles; then IDLE, tx_ready may assert.
//   dc_c and mosi hold their last values while idle; dc_c changes only while cs=1.
//   Reset mid-frame: outputs go to reset values immediately; partial word is discarded.
// TESTING (CLK_DIV=2 DATA_W=8 CS_GAP=2 PWR_DELAY=10 RES_CYCLES=5 VCC_OFF_DELAY=8)
//  Power-up: pwr_on_req=1 at cycle 0 -> pmod_en=1 from cycle 1, res=0 cycles 11-15,
//   pwr_ready=1 at cycle 21.
//  Word: 0xA5, tx_dc=0 -> rising-edge samples 1,0,1,0,0,1,0,1; dc_c=0;
//   cs low 34 cycles; tx_ready high after the 2-cycle gap.
//  Back-to-back: 0x81 cmd then 0x3C data, tx_valid held -> cs high exactly 2 cycles
//   between frames; dc_c 0->1 only while cs=1.
//  Power-down mid-word: pwr_on_req=0 during bit 3 -> word completes; pwr_ready=0;
//   vss_en=0 after gap; pmod_en=0 and res=0 8 cycles later.
//  VCC gating: vcc_req=1 from cycle 0 -> vss_en=0 until pwr_ready, then 1 one cycle later.
//  Async reset: rst_n=0 mid-SHIFT -> cs=1 sclk=1 res=0 pmod_en=0 without waiting
//   for a clk edge.

Source files
------------

// File: rtl/oled_spi_master_if.sv
// Bundle between the display controller and the Pmod OLED RGB pins:
// power requests, valid/ready word stream and the SPI/power pin set.
interface oled_spi_master_if #(
    parameter int DATA_W = 8
);
    logic              pwr_on_req;
    logic              vcc_req;
    logic              pwr_ready;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_dc;
    logic              busy;
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              dc_c;
    logic              res;
    logic              vss_en;
    logic              pmod_en;

    modport master (
        output pwr_on_req, vcc_req, tx_valid, tx_data, tx_dc,
        input  pwr_ready, tx_ready, busy, sclk, cs, mosi, dc_c, res, vss_en, pmod_en
    );

    modport slave (
        input  pwr_on_req, vcc_req, tx_valid, tx_data, tx_dc,
        output pwr_ready, tx_ready, busy, sclk, cs, mosi, dc_c, res, vss_en, pmod_en
    );
endinterface

// File: rtl/oled_spi_master.sv
// Pmod OLED RGB driver: SPI mode 3 word serialiser plus panel power sequencer
// (VDD on, reset pulse, VCC gating, ordered power-down). All pins registered.
module oled_spi_master #(
    parameter int CLK_DIV       = 4,
    parameter int DATA_W        = 8,
    parameter int CS_GAP        = 2,
    parameter int PWR_DELAY     = 1000,
    parameter int RES_CYCLES    = 500,
    parameter int VCC_OFF_DELAY = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    oled_spi_master_if.slave   bus
);

    localparam int SMAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int SCW   = $clog2(SMAX + 1);
    localparam int BW    = $clog2(DATA_W + 1);
    localparam int PMAX0 = (PWR_DELAY > RES_CYCLES) ? PWR_DELAY : RES_CYCLES;
    localparam int PMAX  = (PMAX0 > VCC_OFF_DELAY) ? PMAX0 : VCC_OFF_DELAY;
    localparam int PCW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        P_OFF, P_VDD_ON, P_RES_LO, P_RES_HI, P_READY, P_DRAIN, P_PWR_DOWN
    } pwr_st_e;

    typedef enum logic [1:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_GAP
    } spi_st_e;

    pwr_st_e           pwr_st_q;
    logic [PCW-1:0]    pcnt_q;
    logic              res_q, vss_en_q, pmod_en_q, pwr_ready_q;

    spi_st_e           spi_st_q;
    logic [SCW-1:0]    scnt_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] sh_q;
    logic              sclk_q, cs_q, mosi_q, dc_q, tx_ready_q, busy_q;

    logic              accept;
    logic              rdy_ok;
    logic [DATA_W-1:0] sh_nx;

    assign accept = bus.tx_valid && tx_ready_q;
    assign rdy_ok = (pwr_st_q == P_READY) && bus.pwr_on_req;
    assign sh_nx  = sh_q << 1;

    // Power sequencer. DRAIN holds VCC until the SPI side has finished its
    // frame and cs gap, so the panel never loses VCC mid-word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_st_q    <= P_OFF;
            pcnt_q      <= '0;
            res_q       <= 1'b0;
            vss_en_q    <= 1'b0;
            pmod_en_q   <= 1'b0;
            pwr_ready_q <= 1'b0;
        end else begin
            unique case (pwr_st_q)
                P_OFF: begin
                    if (bus.pwr_on_req) begin
                        pwr_st_q  <= P_VDD_ON;
                        pcnt_q    <= PCW'(PWR_DELAY - 1);
                        pmod_en_q <= 1'b1;
                        res_q     <= 1'b1;
                    end
                end
                P_VDD_ON: begin
                    if (!bus.pwr_on_req) begin
                        pwr_st_q  <= P_OFF;
                        pmod_en_q <= 1'b0;
                        res_q     <= 1'b0;
                    end else if (pcnt_q == '0) begin
                        pwr_st_q <= P_RES_LO;
                        pcnt_q   <= PCW'(RES_CYCLES - 1);
                        res_q    <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                P_RES_LO: begin
                    if (!bus.pwr_on_req) begin
                        pwr_st_q  <= P_OFF;
                        pmod_en_q <= 1'b0;
                        res_q     <= 1'b0;
                    end else if (pcnt_q == '0) begin
                        pwr_st_q <= P_RES_HI;
                        pcnt_q   <= PCW'(RES_CYCLES - 1);
                        res_q    <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                P_RES_HI: begin
                    if (!bus.pwr_on_req) begin
                        pwr_st_q  <= P_OFF;
                        pmod_en_q <= 1'b0;
                        res_q     <= 1'b0;
                    end else if (pcnt_q == '0) begin
                        pwr_st_q    <= P_READY;
                        pwr_ready_q <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                P_READY: begin
                    if (!bus.pwr_on_req) begin
                        pwr_st_q    <= P_DRAIN;
                        pwr_ready_q <= 1'b0;
                    end else begin
                        vss_en_q <= bus.vcc_req;
                    end
                end
                P_DRAIN: begin
                    if (spi_st_q == S_IDLE) begin
                        pwr_st_q <= P_PWR_DOWN;
                        pcnt_q   <= PCW'(VCC_OFF_DELAY - 1);
                        vss_en_q <= 1'b0;
                    end
                end
                P_PWR_DOWN: begin
                    if (pcnt_q == '0) begin
                        pwr_st_q  <= P_OFF;
                        pmod_en_q <= 1'b0;
                        res_q     <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                default: begin
                    pwr_st_q  <= P_OFF;
                    pmod_en_q <= 1'b0;
                    res_q     <= 1'b0;
                    vss_en_q  <= 1'b0;
                end
            endcase
        end
    end

    // SPI serialiser. tx_ready is raised in the last gap cycle so a held
    // tx_valid restarts cs exactly CS_GAP cycles after it rose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_st_q   <= S_IDLE;
            scnt_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            sclk_q     <= 1'b1;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            dc_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_ready_q <= 1'b0;
            if (accept) begin
                spi_st_q <= S_SETUP;
                scnt_q   <= SCW'(CLK_DIV - 1);
                bit_q    <= '0;
                sh_q     <= bus.tx_data;
                mosi_q   <= bus.tx_data[DATA_W-1];
                dc_q     <= bus.tx_dc;
                cs_q     <= 1'b0;
                sclk_q   <= 1'b1;
                busy_q   <= 1'b1;
            end else begin
                unique case (spi_st_q)
                    S_IDLE: tx_ready_q <= rdy_ok;
                    S_SETUP: begin
                        if (scnt_q == '0) begin
                            spi_st_q <= S_SHIFT;
                            sclk_q   <= 1'b0;
                            scnt_q   <= SCW'(CLK_DIV - 1);
                        end else begin
                            scnt_q <= scnt_q - 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (scnt_q != '0) begin
                            scnt_q <= scnt_q - 1'b1;
                        end else if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            scnt_q <= SCW'(CLK_DIV - 1);
                        end else if (bit_q == BW'(DATA_W - 1)) begin
                            spi_st_q   <= S_GAP;
                            cs_q       <= 1'b1;
                            scnt_q     <= SCW'(CS_GAP - 1);
                            tx_ready_q <= (CS_GAP == 1) && rdy_ok;
                        end else begin
                            sclk_q <= 1'b0;
                            scnt_q <= SCW'(CLK_DIV - 1);
                            bit_q  <= bit_q + 1'b1;
                            sh_q   <= sh_nx;
                            mosi_q <= sh_nx[DATA_W-1];
                        end
                    end
                    S_GAP: begin
                        if (scnt_q != '0) begin
                            scnt_q     <= scnt_q - 1'b1;
                            tx_ready_q <= (scnt_q == SCW'(1)) && rdy_ok;
                        end else begin
                            spi_st_q   <= S_IDLE;
                            busy_q     <= 1'b0;
                            tx_ready_q <= rdy_ok;
                        end
                    end
                    default: spi_st_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.cs        = cs_q;
    assign bus.mosi      = mosi_q;
    assign bus.dc_c      = dc_q;
    assign bus.res       = res_q;
    assign bus.vss_en    = vss_en_q;
    assign bus.pmod_en   = pmod_en_q;
    assign bus.pwr_ready = pwr_ready_q;
    assign bus.tx_ready  = tx_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_oled_spi_master.sv
// Scoreboard bench for oled_spi_master: words queued at issue, a pin-level
// monitor rebuilds each SPI frame and compares; power sequence checked per cycle.
module tb_oled_spi_master;

    localparam int CLK_DIV       = 2;
    localparam int DATA_W        = 8;
    localparam int CS_GAP        = 2;
    localparam int PWR_DELAY     = 10;
    localparam int RES_CYCLES    = 5;
    localparam int VCC_OFF_DELAY = 8;
    localparam int CS_LOW        = CLK_DIV * (1 + 2 * DATA_W);

    typedef struct {
        logic [7:0] data;
        logic       dc;
        bit         exact;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    oled_spi_master_if #(.DATA_W(DATA_W)) bus();

    oled_spi_master #(
        .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CS_GAP(CS_GAP),
        .PWR_DELAY(PWR_DELAY), .RES_CYCLES(RES_CYCLES), .VCC_OFF_DELAY(VCC_OFF_DELAY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pin monitor: rebuilds each frame from rising-sclk samples while cs is low.
    logic       prev_cs = 1'b1, prev_sclk = 1'b1, dc_frame = 1'b0;
    logic [7:0] shv = '0;
    bit         in_frame = 0, have_rise = 0, dc_ok = 1, sclk_fall_ok = 1;
    int         nbits = 0, low_len = 0, rise_cyc = 0, gap_meas = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 0;
            have_rise = 0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
        end else begin
            if (prev_cs && !bus.cs) begin
                in_frame     = 1;
                nbits        = 0;
                low_len      = 0;
                shv          = '0;
                dc_ok        = 1;
                dc_frame     = bus.dc_c;
                sclk_fall_ok = bus.sclk;
                gap_meas     = have_rise ? (cyc - rise_cyc) : -1;
            end
            if (!bus.cs && in_frame) begin
                low_len++;
                if (!prev_sclk && bus.sclk) begin
                    shv = {shv[6:0], bus.mosi};
                    nbits++;
                end
                if (bus.dc_c !== dc_frame) dc_ok = 0;
            end
            if (!prev_cs && bus.cs && in_frame) begin
                in_frame = 0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got word 0x%0h, none queued", shv);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_data", shv, e.data);
                    chk("frame_dc", dc_frame, e.dc);
                    chk("frame_bits", nbits, DATA_W);
                    chk("frame_cs_low", low_len, CS_LOW);
                    chk("frame_sclk_high_at_cs_edges", sclk_fall_ok & bus.sclk, 1);
                    chk("frame_dc_stable", dc_ok, 1);
                    if (gap_meas >= 0) begin
                        if (e.exact) chk("frame_cs_gap_exact", gap_meas, CS_GAP);
                        else         chk("frame_cs_gap_min", gap_meas >= CS_GAP, 1);
                    end
                end
                have_rise = 1;
                rise_cyc  = cyc;
            end
            prev_cs   = bus.cs;
            prev_sclk = bus.sclk;
        end
    end

    // Present a word after pre idle cycles; queue its expectation once it will be taken.
    task automatic send(input logic [7:0] d, input logic dc, input int pre, input bit exact);
        exp_t e;
        bus.tx_valid = 1'b0;
        repeat (pre) @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        bus.tx_dc    = dc;
        for (int t = 0; t < 400; t++) begin
            if (bus.tx_ready) begin
                e.data  = d;
                e.dc    = dc;
                e.exact = exact;
                exp_q.push_back(e);
                @(negedge clk);
                bus.tx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got tx_ready=0 for 400 cycles, required 1");
        bus.tx_valid = 1'b0;
    endtask

    function automatic logic [3:0] pwr_model(input int k);
        logic pm, rs, pr, vs;
        pm = (k >= 1);
        rs = (k >= 1 && k <= PWR_DELAY) || (k > PWR_DELAY + RES_CYCLES);
        pr = (k > PWR_DELAY + 2 * RES_CYCLES);
        vs = (k > PWR_DELAY + 2 * RES_CYCLES + 1);
        return {pm, rs, pr, vs};
    endfunction

    initial begin
        int r_cyc, vf, pf, pr;
        bit txr_seen;
        logic res_at_pf;

        rst_n = 1'b0;
        bus.pwr_on_req = 1'b0;
        bus.vcc_req    = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.tx_dc      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.cs, bus.sclk, bus.mosi, bus.dc_c, bus.res, bus.vss_en,
                              bus.pmod_en, bus.pwr_ready, bus.tx_ready, bus.busy}, 10'b11_0000_0000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("off_stays_off", {bus.pmod_en, bus.res, bus.pwr_ready}, 3'b000);

        // Abort during VDD_ON returns straight to OFF.
        bus.pwr_on_req = 1'b1;
        bus.vcc_req    = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_vdd_on", {bus.pmod_en, bus.res}, 2'b11);
        bus.pwr_on_req = 1'b0;
        @(negedge clk);
        chk("abort_to_off", {bus.pmod_en, bus.res, bus.vss_en}, 3'b000);
        repeat (2) @(negedge clk);

        // Full power-up, vcc_req held high from cycle 0.
        bus.pwr_on_req = 1'b1;
        chk("pwrup_k0", {bus.pmod_en, bus.res, bus.pwr_ready, bus.vss_en}, pwr_model(0));
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            chk($sformatf("pwrup_k%0d", k), {bus.pmod_en, bus.res, bus.pwr_ready, bus.vss_en},
                pwr_model(k));
        end

        // Directed words, then randomised stream.
        send(8'hA5, 1'b0, 2, 0);
        send(8'h81, 1'b0, 50, 0);
        send(8'h3C, 1'b1, 0, 1);
        for (int i = 0; i < 24; i++) begin
            int r, pre;
            r   = $urandom_range(0, 7);
            pre = (r == 0) ? 45 : (r % 4);
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), pre, pre < 20);
        end
        for (int t = 0; t < 2000; t++) begin
            if (exp_q.size() == 0 && !bus.busy) break;
            @(negedge clk);
        end
        chk("stream_drained", exp_q.size(), 0);

        // Power-down requested during bit 3 of a word.
        send(8'h5A, 1'b1, 2, 0);
        repeat (CLK_DIV + 2 * CLK_DIV * 3 - 1) @(negedge clk);
        bus.pwr_on_req = 1'b0;
        @(negedge clk);
        chk("pd_pwr_ready_drop", bus.pwr_ready, 0);
        chk("pd_vss_held_in_frame", {bus.vss_en, bus.cs}, 2'b10);
        r_cyc = -1; vf = -1; pf = -1; pr = -1; txr_seen = 0; res_at_pf = 1'b1;
        for (int t = 0; t < 200 && pr < 0; t++) begin
            if (vf < 0 && bus.tx_ready) txr_seen = 1;
            if (r_cyc < 0 && bus.cs) r_cyc = cyc;
            if (vf < 0 && !bus.vss_en) begin
                vf = cyc;
                bus.pwr_on_req = 1'b1;
            end
            if (vf >= 0 && pf < 0 && !bus.pmod_en) begin
                pf = cyc;
                res_at_pf = bus.res;
            end
            if (pf >= 0 && bus.pmod_en) pr = cyc;
            @(negedge clk);
        end
        chk("pd_no_accept_while_draining", txr_seen, 0);
        chk("pd_vss_after_gap", (r_cyc >= 0) && (vf >= r_cyc + CS_GAP) && (vf <= r_cyc + CS_GAP + 2), 1);
        chk("pd_pmod_off_delay", pf - vf, VCC_OFF_DELAY);
        chk("pd_res_low_at_off", res_at_pf, 0);
        chk("pd_repower_after_off", pr - pf, 1);

        for (int t = 0; t < 100; t++) begin
            if (bus.pwr_ready) break;
            @(negedge clk);
        end
        chk("repower_ready", bus.pwr_ready, 1);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of SHIFT.
        send(8'hC3, 1'b0, 0, 0);
        repeat (8) @(negedge clk);
        chk("pre_reset_mid_frame", {bus.cs, bus.busy}, 2'b01);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pins", {bus.cs, bus.sclk, bus.res, bus.pmod_en, bus.vss_en,
                                 bus.pwr_ready, bus.busy}, 7'b1100000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        bus.pwr_on_req = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", {bus.cs, bus.pmod_en, bus.busy}, 3'b100);
        chk("no_stray_frames", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
